axi_stream_packet_fifo: RTL and testbench

Parametrised AXI4-Stream buffer placed between an axi_stream_master and an axi_stream_slave.
- Supports generic data width, depth and TLAST framing.
- Optional store-and-forward packet mode: a packet is presented downstream only after it has been fully received.
- Replaces the fixed 32-bit, 8-entry sink buffering.

---
 rtl/axi_stream_pkg.sv | 22 ++
 rtl/axi_stream_packet_fifo_if.sv | 14 +
 rtl/axi_stream_fifo_mem.sv | 23 ++
 rtl/axi_stream_packet_fifo.sv | 117 +++++++++++
 tb/tb_axi_stream_packet_fifo.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_pkg.sv
// Shared AXI4-Stream types and defaults for the stream buffering blocks.
package axi_stream_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 16;

    // Legacy fixed-width beat type, still used by older blocks.
    typedef logic [31:0] data_t;

    // One stored FIFO entry at the default width: end-of-packet flag above the data.
    typedef struct packed {
        logic                          last;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } entry_t;

    // Store-and-forward override: OPEN lets a packet drain before its TLAST arrives.
    typedef enum logic {
        REL_HOLD = 1'b0,
        REL_OPEN = 1'b1
    } rel_state_t;

endpackage

// File: rtl/axi_stream_packet_fifo_if.sv
// One AXI4-Stream link; master drives payload/valid, slave drives ready.
interface axi_stream_packet_fifo_if
    import axi_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi_stream_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module axi_stream_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_stream_packet_fifo.sv
// First-word fall-through AXI4-Stream FIFO with optional store-and-forward packet mode.
module axi_stream_packet_fifo
    import axi_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned PACKET_MODE = 0
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    axi_stream_packet_fifo_if.slave    s,
    axi_stream_packet_fifo_if.master   m,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       oversize
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] rd_entry;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    rel_state_t    rel_state;
    rel_state_t    rel_next;
    logic          set_oversize;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign s.tready = areset_n && !full;
    assign m.tvalid = !empty && ((PACKET_MODE == 0) || (pkt_count != '0) || (rel_state == REL_OPEN));
    assign m.tdata  = rd_entry[DATA_WIDTH-1:0];
    assign m.tlast  = rd_entry[DATA_WIDTH];

    assign wr_en = s.tvalid && s.tready;
    assign rd_en = m.tvalid && m.tready;

    axi_stream_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (aclk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({s.tlast, s.tdata}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    // Read/write pointer advance on handshakes.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Count of stored TLAST beats, i.e. complete packets held.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pkt_count <= '0;
        end else begin
            unique case ({wr_en && s.tlast, rd_en && m.tlast})
                2'b10:   pkt_count <= pkt_count + PW'(1);
                2'b01:   pkt_count <= pkt_count - PW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Release state register.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rel_state <= REL_HOLD;
        end else begin
            rel_state <= rel_next;
        end
    end

    // Open the release when full with no complete packet (would deadlock); close on TLAST read.
    always_comb begin
        rel_next     = rel_state;
        set_oversize = 1'b0;
        case (rel_state)
            REL_HOLD: begin
                if ((PACKET_MODE != 0) && full && (pkt_count == '0)) begin
                    rel_next     = REL_OPEN;
                    set_oversize = 1'b1;
                end
            end
            REL_OPEN: begin
                if (rd_en && m.tlast) begin
                    rel_next = REL_HOLD;
                end
            end
            default: rel_next = REL_HOLD;
        endcase
    end

    // Sticky oversize flag, cleared only by reset.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            oversize <= 1'b0;
        end else if (set_oversize) begin
            oversize <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_stream_packet_fifo.sv
// Directed scoreboard bench for axi_stream_packet_fifo: one cut-through and one packet-mode instance.
module tb_axi_stream_packet_fifo;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    logic          clk;
    logic          rst_n;
    int            sel;
    logic [DW-1:0] d_tdata;
    logic          d_tlast;
    logic          d_tvalid;
    logic          d_mready;

    logic [DW-1:0] o_tdata;
    logic          o_tlast;
    logic          o_mvalid;
    logic          o_sready;
    logic [CW-1:0] o_count;
    logic [CW-1:0] o_pkt;
    logic          o_over;

    logic [CW-1:0] cnt0, cnt1, pk0, pk1;
    logic          ov0, ov1;

    int tests;
    int fails;
    logic [DW:0] sb [$];

    axi_stream_packet_fifo_if #(.DATA_WIDTH(DW)) s0_if ();
    axi_stream_packet_fifo_if #(.DATA_WIDTH(DW)) m0_if ();
    axi_stream_packet_fifo_if #(.DATA_WIDTH(DW)) s1_if ();
    axi_stream_packet_fifo_if #(.DATA_WIDTH(DW)) m1_if ();

    assign s0_if.tdata  = d_tdata;
    assign s0_if.tlast  = d_tlast;
    assign s0_if.tvalid = (sel == 0) ? d_tvalid : 1'b0;
    assign m0_if.tready = (sel == 0) ? d_mready : 1'b0;
    assign s1_if.tdata  = d_tdata;
    assign s1_if.tlast  = d_tlast;
    assign s1_if.tvalid = (sel == 1) ? d_tvalid : 1'b0;
    assign m1_if.tready = (sel == 1) ? d_mready : 1'b0;

    axi_stream_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .PACKET_MODE(0)) u_dut0 (
        .aclk      (clk),
        .areset_n  (rst_n),
        .s         (s0_if.slave),
        .m         (m0_if.master),
        .count     (cnt0),
        .pkt_count (pk0),
        .oversize  (ov0)
    );

    axi_stream_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .PACKET_MODE(1)) u_dut1 (
        .aclk      (clk),
        .areset_n  (rst_n),
        .s         (s1_if.slave),
        .m         (m1_if.master),
        .count     (cnt1),
        .pkt_count (pk1),
        .oversize  (ov1)
    );

    // Observe whichever instance is currently selected.
    always_comb begin
        if (sel == 0) begin
            o_sready = s0_if.tready; o_mvalid = m0_if.tvalid;
            o_tdata  = m0_if.tdata;  o_tlast  = m0_if.tlast;
            o_count  = cnt0; o_pkt = pk0; o_over = ov0;
        end else begin
            o_sready = s1_if.tready; o_mvalid = m1_if.tvalid;
            o_tdata  = m1_if.tdata;  o_tlast  = m1_if.tlast;
            o_count  = cnt1; o_pkt = pk1; o_over = ov1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sb_pkts();
        int n = 0;
        foreach (sb[i]) if (sb[i][DW]) n++;
        return n;
    endfunction

    // One clock cycle: settle, score handshakes, cross the edge, return at the next falling edge.
    task automatic tick(output bit acc);
        bit rd, wr;
        logic [DW:0] exp;
        #1;
        rd = o_mvalid && d_mready;
        wr = d_tvalid && o_sready;
        if (rd) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL rd_unexpected observed=%0h expected=none", {o_tlast, o_tdata});
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("rd_beat", 64'({o_tlast, o_tdata}), 64'(exp));
            end
        end
        if (wr) sb.push_back({d_tlast, d_tdata});
        acc = wr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        bit acc;
        int n = 0;
        d_tvalid = 1'b0;
        d_mready = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            tick(acc);
            n++;
        end
        chk("drain_done", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        bit acc;
        bit saw_full;
        int sent;
        int n;
        tests = 0; fails = 0;
        sel = 0; rst_n = 1'b0;
        d_tdata = '0; d_tlast = 1'b0; d_tvalid = 1'b0; d_mready = 1'b0;

        // Reset state.
        @(negedge clk); #1;
        chk("rst_mvalid0", 64'(m0_if.tvalid), 64'(0));
        chk("rst_sready0", 64'(s0_if.tready), 64'(0));
        chk("rst_mvalid1", 64'(m1_if.tvalid), 64'(0));
        chk("rst_count1",  64'(cnt1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fill cut-through FIFO with ready low, then drain in order.
        sel = 0; d_mready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d_tdata = 32'hdeadbeef + 32'(i); d_tlast = 1'b0; d_tvalid = 1'b1;
            tick(acc);
        end
        #1;
        chk("t1_full_sready", 64'(o_sready), 64'(0));
        chk("t1_full_count",  64'(o_count), 64'(16));
        chk("t1_head",        64'(o_tdata), 64'(32'hdeadbeef));
        drain(40);
        #1;
        chk("t1_empty_count",  64'(o_count), 64'(0));
        chk("t1_empty_mvalid", 64'(o_mvalid), 64'(0));

        // Cut-through latency: each beat visible the cycle after it is written.
        d_mready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d_tdata = 32'hdeadbeef + 32'(i); d_tlast = (i == 7); d_tvalid = 1'b1;
            #1;
            if (i == 0) chk("t2_no_bypass", 64'(o_mvalid), 64'(0));
            else        chk("t2_prev_beat", 64'({o_mvalid, o_tdata}), 64'({1'b1, 32'hdeadbeef + 32'(i - 1)}));
            tick(acc);
        end
        drain(10);
        #1;
        chk("t2_pkt_count", 64'(o_pkt), 64'(0));

        // Store-and-forward: nothing leaves until TLAST is written.
        sel = 1; d_mready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_tdata = 32'h1000 + 32'(i); d_tlast = 1'b0; d_tvalid = 1'b1;
            tick(acc);
        end
        #1;
        chk("t3_held_mvalid", 64'(o_mvalid), 64'(0));
        chk("t3_held_pkt",    64'(o_pkt), 64'(0));
        chk("t3_held_count",  64'(o_count), 64'(3));
        d_tdata = 32'h1003; d_tlast = 1'b1;
        tick(acc);
        d_tvalid = 1'b0;
        #1;
        chk("t3_rel_mvalid", 64'(o_mvalid), 64'(1));
        chk("t3_rel_pkt",    64'(o_pkt), 64'(1));
        drain(10);

        // Steady state at count 5 with simultaneous read and write.
        sel = 0; d_mready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_tdata = 32'h2000 + 32'(i); d_tlast = (i % 3 == 2); d_tvalid = 1'b1;
            tick(acc);
        end
        d_mready = 1'b1;
        for (int i = 5; i < 15; i++) begin
            d_tdata = 32'h2000 + 32'(i); d_tlast = (i % 3 == 2); d_tvalid = 1'b1;
            #1;
            chk("t4_count", 64'(o_count), 64'(5));
            chk("t4_pkt",   64'(o_pkt), 64'(sb_pkts()));
            tick(acc);
        end
        drain(20);

        // Oversize packet in store-and-forward mode.
        sel = 1; d_mready = 1'b1;
        #1;
        chk("t5_over_before", 64'(o_over), 64'(0));
        sent = 0; n = 0; saw_full = 1'b0;
        while (sent < 20 && n < 200) begin
            d_tdata = 32'hdeadbeef + 32'(sent); d_tlast = (sent == 19); d_tvalid = 1'b1;
            #1;
            if (o_count == CW'(16)) saw_full = 1'b1;
            tick(acc);
            if (acc) sent++;
            n++;
        end
        chk("t5_sent", 64'(sent), 64'(20));
        chk("t5_saw_full", 64'(saw_full), 64'(1));
        drain(60);
        #1;
        chk("t5_over_after", 64'(o_over), 64'(1));
        // Release closed again: a normal packet is held until its TLAST.
        d_tdata = 32'h3000; d_tlast = 1'b0; d_tvalid = 1'b1;
        tick(acc);
        d_tvalid = 1'b0;
        #1;
        chk("t5_rehold", 64'(o_mvalid), 64'(0));
        d_tdata = 32'h3001; d_tlast = 1'b1; d_tvalid = 1'b1;
        tick(acc);
        drain(10);
        #1;
        chk("t5_over_sticky", 64'(o_over), 64'(1));

        // Reset mid-packet discards contents.
        d_mready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            d_tdata = 32'h4000 + 32'(i); d_tlast = 1'b0; d_tvalid = 1'b1;
            tick(acc);
        end
        d_tvalid = 1'b0;
        #1;
        chk("t6_count7", 64'(o_count), 64'(7));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mvalid", 64'(o_mvalid), 64'(0));
        chk("t6_rst_count",  64'(o_count), 64'(0));
        chk("t6_rst_over",   64'(o_over), 64'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_sready", 64'(o_sready), 64'(1));
        d_mready = 1'b1;
        d_tdata = 32'h5000; d_tlast = 1'b0; d_tvalid = 1'b1;
        tick(acc);
        d_tdata = 32'h5001; d_tlast = 1'b1;
        tick(acc);
        drain(10);
        #1;
        chk("t6_pkt_end", 64'(o_pkt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
